// File: rtl/control_panel_seq.sv
// Operator panel front end plus run/stop/halt sequencer for the EDSAC control unit.
// Multi-step mode (btn_multi, step_count, STEPPING, steps_left) is built only with CTRL_PANEL_MULTISTEP_EN.
module control_panel_seq #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STEP_W          = 8
) (
    input  logic              clk,
    input  logic              reset_neg,
    input  logic              btn_start,
    input  logic              btn_stop,
    input  logic              btn_resume,
    input  logic              btn_single,
    input  logic              btn_extended,
    input  logic              btn_multi,
    input  logic [STEP_W-1:0] step_count,
    input  logic              s2,
    input  logic              c22,
    input  logic              d18,
    input  logic              d35,
    input  logic              ep,
    input  logic              sep2,
    input  logic              starter_neg,
    output logic              start,
    output logic              single_ep,
    output logic              epsep,
    output logic              ep11,
    output logic              stop_neg,
    output logic              extended_pos,
    output logic              extended_neg,
    output logic              running,
    output logic [STEP_W-1:0] steps_left,
    // 0 STOPPED, 1 RUNNING, 2 HALTING, 3 STEPPING
    output logic [1:0]        state_dbg
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int B_START  = 0;
    localparam int B_STOP   = 1;
    localparam int B_RESUME = 2;
    localparam int B_SINGLE = 3;
    localparam int B_EXT    = 4;

`ifdef CTRL_PANEL_MULTISTEP_EN
    localparam int NB      = 6;
    localparam int B_MULTI = 5;
    logic [NB-1:0] raw;
    assign raw = {btn_multi, btn_extended, btn_single, btn_resume, btn_stop, btn_start};
`else
    localparam int NB = 5;
    logic [NB-1:0] raw;
    logic          unused_multi;
    assign raw          = {btn_extended, btn_single, btn_resume, btn_stop, btn_start};
    assign unused_multi = ^{btn_multi, step_count};
`endif

    logic [NB-1:0] sync1_q, sync2_q, stable_q, stable_dly_q, pulse_q;
    logic [CW-1:0] cnt_q [NB];

    // Stable level flips only after DEBOUNCE_CYCLES consecutive samples that disagree with it.
    always_ff @(posedge clk) begin
        if (!reset_neg) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            pulse_q      <= '0;
            for (int b = 0; b < NB; b++) cnt_q[b] <= '0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            stable_dly_q <= stable_q;
            pulse_q      <= stable_q & ~stable_dly_q;
            for (int b = 0; b < NB; b++) begin
                if (sync2_q[b] == stable_q[b]) begin
                    cnt_q[b] <= '0;
                end else if (cnt_q[b] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    stable_q[b] <= sync2_q[b];
                    cnt_q[b]    <= '0;
                end else begin
                    cnt_q[b] <= cnt_q[b] + CW'(1);
                end
            end
        end
    end

    typedef enum logic [1:0] {
        ST_STOPPED  = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_HALTING  = 2'd2
`ifdef CTRL_PANEL_MULTISTEP_EN
        ,
        ST_STEPPING = 2'd3
`endif
    } state_t;

    state_t state_q, state_d;
    logic   armed_q, armed_d;
    logic   ep11_q, ep11_d;
    logic   ext_q, ext_d;
    logic   cause, start_c, single_c;
`ifdef CTRL_PANEL_MULTISTEP_EN
    logic [STEP_W-1:0] left_q, left_d;
`endif

    assign cause = pulse_q[B_STOP] | c22 | s2 | ~starter_neg;

    always_comb begin
        state_d  = state_q;
        armed_d  = armed_q;
        ep11_d   = 1'b0;
        ext_d    = ext_q ^ pulse_q[B_EXT];
        start_c  = 1'b0;
        single_c = 1'b0;
`ifdef CTRL_PANEL_MULTISTEP_EN
        left_d   = left_q;
`endif
        case (state_q)
            ST_STOPPED: begin
                // A halt cause in the same cycle suppresses every button action.
                if (!cause) begin
                    start_c  = pulse_q[B_START];
                    single_c = pulse_q[B_RESUME] | pulse_q[B_SINGLE];
                    if (pulse_q[B_START] || pulse_q[B_RESUME]) begin
                        state_d = ST_RUNNING;
                    end
`ifdef CTRL_PANEL_MULTISTEP_EN
                    else if (pulse_q[B_MULTI] && step_count != '0) begin
                        left_d  = step_count;
                        state_d = ST_STEPPING;
                    end
`endif
                end
            end
            ST_RUNNING: begin
                if (cause) state_d = ST_HALTING;
            end
`ifdef CTRL_PANEL_MULTISTEP_EN
            ST_STEPPING: begin
                if (cause) begin
                    left_d  = '0;
                    state_d = ST_HALTING;
                end else if (ep && left_q != '0) begin
                    left_d = left_q - STEP_W'(1);
                    if (left_q == STEP_W'(1)) state_d = ST_HALTING;
                end
            end
`endif
            ST_HALTING: begin
                // Arming uses the registered flag, so a coincident d18/d35 only arms.
                if (ep11_q) begin
                    state_d = ST_STOPPED;
                    armed_d = 1'b0;
                end else begin
                    if (d18) armed_d = 1'b1;
                    ep11_d = armed_q & d35;
                end
            end
            default: state_d = ST_STOPPED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_neg) begin
            state_q <= ST_STOPPED;
            armed_q <= 1'b0;
            ep11_q  <= 1'b0;
            ext_q   <= 1'b0;
`ifdef CTRL_PANEL_MULTISTEP_EN
            left_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            ep11_q  <= ep11_d;
            ext_q   <= ext_d;
`ifdef CTRL_PANEL_MULTISTEP_EN
            left_q  <= left_d;
`endif
        end
    end

    assign start        = start_c;
    assign single_ep    = single_c | sep2;
    assign epsep        = ep | single_ep;
    assign ep11         = ep11_q;
    assign stop_neg     = (state_q != ST_STOPPED);
    assign extended_pos = ext_q;
    assign extended_neg = ~ext_q;
    assign state_dbg    = state_q;
`ifdef CTRL_PANEL_MULTISTEP_EN
    assign running      = (state_q == ST_RUNNING) || (state_q == ST_STEPPING);
    assign steps_left   = left_q;
`else
    assign running      = (state_q == ST_RUNNING);
    assign steps_left   = '0;
`endif

endmodule

// File: tb/tb_control_panel_seq.sv
// Self-checking bench for control_panel_seq: directed scenarios plus random panel/timing traffic
// compared every cycle against a behavioural model of the panel rules.
module tb_control_panel_seq;
  localparam int D  = 4;
  localparam int SW = 8;
`ifdef CTRL_PANEL_MULTISTEP_EN
  localparam bit MULTI = 1'b1;
`else
  localparam bit MULTI = 1'b0;
`endif
  localparam int M_STOP = 0, M_RUN = 1, M_HALT = 2, M_STEP = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_neg = 1'b0;
  logic [5:0]    btn = '0;  // 0 start 1 stop 2 resume 3 single 4 extended 5 multi
  logic [SW-1:0] step_count = '0;
  logic s2 = 0, c22 = 0, d18 = 0, d35 = 0, ep = 0, sep2 = 0, starter_neg = 1;
  logic start, single_ep, epsep, ep11, stop_neg, extended_pos, extended_neg, running;
  logic [SW-1:0] steps_left;
  logic [1:0]    state_dbg;

  control_panel_seq #(.DEBOUNCE_CYCLES(D), .STEP_W(SW)) dut (
    .clk(clk), .reset_neg(reset_neg),
    .btn_start(btn[0]), .btn_stop(btn[1]), .btn_resume(btn[2]),
    .btn_single(btn[3]), .btn_extended(btn[4]), .btn_multi(btn[5]),
    .step_count(step_count), .s2(s2), .c22(c22), .d18(d18), .d35(d35),
    .ep(ep), .sep2(sep2), .starter_neg(starter_neg),
    .start(start), .single_ep(single_ep), .epsep(epsep), .ep11(ep11),
    .stop_neg(stop_neg), .extended_pos(extended_pos), .extended_neg(extended_neg),
    .running(running), .steps_left(steps_left), .state_dbg(state_dbg)
  );

  // scoreboard counters
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // behavioural model
  bit        m_s1 [6], m_s2 [6], m_stb [6], m_prv [6], m_pls [6];
  bit [31:0] m_win [6];
  int        m_mode, m_left;
  bit        m_armed, m_ep11, m_ext;

  task automatic model_reset();
    for (int b = 0; b < 6; b++) begin
      m_s1[b] = 0; m_s2[b] = 0; m_stb[b] = 0; m_prv[b] = 0; m_pls[b] = 0; m_win[b] = '0;
    end
    m_mode = M_STOP; m_left = 0; m_armed = 0; m_ep11 = 0; m_ext = 0;
  endtask

  task automatic model_step();
    bit        p [6];
    bit        cause;
    bit [31:0] mask;
    if (!reset_neg) begin
      model_reset();
      return;
    end
    mask = (32'd1 << D) - 1;
    for (int b = 0; b < 6; b++) p[b] = m_pls[b];
    if (!MULTI) p[5] = 0;
    // button path: stable level follows the last D synchronised samples once they all disagree
    for (int b = 0; b < 6; b++) begin
      m_pls[b] = m_stb[b] & ~m_prv[b];
      m_prv[b] = m_stb[b];
      m_win[b] = {m_win[b][30:0], m_s2[b]};
      if ((m_win[b] & mask) == (m_stb[b] ? 32'd0 : mask)) m_stb[b] = ~m_stb[b];
      m_s2[b] = m_s1[b];
      m_s1[b] = btn[b];
    end
    cause = p[1] | c22 | s2 | ~starter_neg;
    m_ext = m_ext ^ p[4];
    case (m_mode)
      M_STOP: if (!cause) begin
        if (p[0] || p[2]) m_mode = M_RUN;
        else if (p[5] && step_count != 0) begin m_mode = M_STEP; m_left = int'(step_count); end
      end
      M_RUN: if (cause) m_mode = M_HALT;
      M_STEP: begin
        if (cause) begin m_left = 0; m_mode = M_HALT; end
        else if (ep && m_left > 0) begin
          m_left = m_left - 1;
          if (m_left == 0) m_mode = M_HALT;
        end
      end
      default: begin
        if (m_ep11) begin m_mode = M_STOP; m_armed = 0; m_ep11 = 0; end
        else begin
          m_ep11 = m_armed & d35;
          if (d18) m_armed = 1;
        end
      end
    endcase
  endtask

  task automatic compare();
    bit cause, stp, e_single;
    int pm;
    pm = MULTI ? 1 : 0;
    cause = m_pls[1] | c22 | s2 | ~starter_neg;
    stp = (m_mode == M_STOP);
    e_single = sep2 | (stp & ~cause & (m_pls[2] | m_pls[3]));
    chk("start", start, stp & ~cause & m_pls[0]);
    chk("single_ep", single_ep, e_single);
    chk("epsep", epsep, ep | e_single);
    chk("ep11", ep11, m_ep11);
    chk("stop_neg", stop_neg, !stp);
    chk("extended_pos", extended_pos, m_ext);
    chk("extended_neg", extended_neg, !m_ext);
    chk("running", running, (m_mode == M_RUN) || (m_mode == M_STEP));
    chk("steps_left", int'(steps_left), m_left * pm);
    chk("state", int'(state_dbg), m_mode);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  // driver tasks
  task automatic press(input int b);
    btn[b] = 1'b1;
    repeat (D + 4) tick();
    btn[b] = 1'b0;
    repeat (D + 4) tick();
  endtask

  task automatic pulse_d18();
    d18 = 1; tick(); d18 = 0;
  endtask

  int hold [6];
  int k_seen, npulse;

  initial begin
    model_reset();
    // reset state
    repeat (3) tick();
    reset_neg = 1'b1;
    tick();
    chk("rst_stop_neg", stop_neg, 0);
    chk("rst_ext_neg", extended_neg, 1);
    chk("rst_steps_left", int'(steps_left), 0);
    chk("rst_running", running, 0);
    chk("rst_ep11", ep11, 0);

    // debounce: 1-0-1 bounce then held high
    btn[0] = 1; tick(); btn[0] = 0; tick(); btn[0] = 1;
    k_seen = 0; npulse = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (start) begin npulse++; if (k_seen == 0) k_seen = k; end
    end
    chk("dbc_latency", k_seen, D + 3);
    chk("dbc_pulses", npulse, 1);
    chk("dbc_running", running, 1);
    btn[0] = 0;
    repeat (D + 4) tick();

    // halt sequence from RUNNING
    c22 = 1; tick(); c22 = 0;
    chk("halt_stop_neg", stop_neg, 1);
    tick();
    pulse_d18();
    repeat (2) tick();
    d35 = 1; tick(); d35 = 0;
    chk("halt_ep11", ep11, 1);
    chk("halt_still_on", stop_neg, 1);
    tick();
    chk("halt_ep11_end", ep11, 0);
    chk("halt_stopped", stop_neg, 0);

    // multi-step
    if (MULTI) begin
      step_count = 3;
      press(5);
      chk("ms_load", int'(steps_left), 3);
      chk("ms_running", running, 1);
      for (int i = 2; i >= 0; i--) begin
        ep = 1; tick(); ep = 0;
        chk("ms_count", int'(steps_left), i);
        tick();
      end
      chk("ms_halting", stop_neg, 1);
      chk("ms_not_run", running, 0);
      pulse_d18();
      d35 = 1; tick(); d35 = 0;
      tick();
      chk("ms_stopped", stop_neg, 0);
    end else begin
      step_count = 5;
      press(5);
      chk("ms_off_stopped", stop_neg, 0);
      chk("ms_off_left", int'(steps_left), 0);
    end

    // simultaneous stop and start in STOPPED
    btn[0] = 1; btn[1] = 1;
    npulse = 0;
    repeat (D + 4) begin tick(); if (start) npulse++; end
    btn[0] = 0; btn[1] = 0;
    repeat (D + 4) tick();
    chk("sim_no_start", npulse, 0);
    chk("sim_stopped", stop_neg, 0);

    // extended toggle
    press(4);
    chk("ext_on", extended_pos, 1);
    press(4);
    chk("ext_off", extended_pos, 0);

    // reset while HALTING and armed
    press(0);
    chk("rh_running", running, 1);
    c22 = 1; tick(); c22 = 0;
    pulse_d18();
    chk("rh_halting", stop_neg, 1);
    reset_neg = 0; tick();
    chk("rh_stopped", stop_neg, 0);
    chk("rh_no_ep11", ep11, 0);
    reset_neg = 1;
    d35 = 1; tick(); d35 = 0;
    chk("rh_no_ep11_d35", ep11, 0);
    tick();
    chk("rh_no_ep11_late", ep11, 0);

    // random traffic
    for (int b = 0; b < 6; b++) hold[b] = $urandom_range(5, 40);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int b = 0; b < 6; b++) begin
        if (hold[b] == 0) begin
          btn[b] = ~btn[b];
          if (btn[b]) hold[b] = $urandom_range(1, 14);
          else if (b == 1) hold[b] = $urandom_range(20, 80);
          else hold[b] = $urandom_range(3, 30);
        end else begin
          hold[b]--;
        end
      end
      step_count  = SW'($urandom_range(0, 5));
      c22         = ($urandom_range(0, 39) == 0);
      s2          = ($urandom_range(0, 39) == 0);
      starter_neg = ($urandom_range(0, 59) != 0);
      d18         = ($urandom_range(0, 5) == 0);
      d35         = ($urandom_range(0, 5) == 0);
      ep          = ($urandom_range(0, 3) == 0);
      sep2        = ($urandom_range(0, 7) == 0);
      reset_neg   = ($urandom_range(0, 599) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/control_panel_seq.md
# control_panel_seq

Parametrised, clocked successor to the EDSAC control-switches unit.
- **Front end:** synchronises and debounces the operator push-buttons.
- **Run/stop control:** a run/stop state machine with an ordered halt sequence (arm on d18, fire ep11 on d35).
- **New behaviour:** an extended-mode toggle and a multi-step mode that runs exactly N EP pulses, then halts.
- **Placement:** sits in the input section between the panel buttons and the main control/timing logic.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed before a button level is accepted (≥1)
- STEP_W, 8, width of the multi-step count

Ports:
- clk  in  1  system clock; all state on rising edge
- reset_neg  in  1  synchronous, active-low reset
- btn_start, btn_stop, btn_resume, btn_single, btn_extended, btn_multi  in  1 each  raw asynchronous panel buttons, active-high
- step_count  in  STEP_W  EP count for multi-step mode
- s2, c22, d18, d35, ep, sep2  in  1 each  timing/order pulses, already in clk domain
- starter_neg  in  1  starter active when 0
- start  out  1  one-cycle start pulse
- single_ep  out  1  internal single-EP pulse OR sep2
- epsep  out  1  ep OR single_ep (combinational)
- ep11  out  1  halt-completion pulse
- stop_neg  out  1  0 = machine stopped, 1 = running or halting
- extended_pos, extended_neg  out  1 each  extended mode and its complement
- running  out  1  state is RUNNING or STEPPING
- steps_left  out  STEP_W  remaining multi-step EPs

## Operation
**Buttons**
- Each button passes through a 2-FF synchroniser, then a debounce counter.
- The stable level updates only after DEBOUNCE_CYCLES consecutive differing samples.
- Rising edge of the stable level yields a one-cycle registered pulse (p_start, p_stop, …).

**Extended mode**
- p_extended toggles extended_pos in any state.
- extended_neg is always ~extended_pos.

**Halt causes** (`cause`): p_stop | c22 | s2 | ~starter_neg | step expiry.

**States**
- STOPPED
  - p_start or p_resume → RUNNING. start = p_start.
  - p_resume also emits a single_ep pulse.
  - p_single → single_ep pulse; state unchanged.
  - p_multi with step_count ≠ 0 → load steps_left = step_count, go STEPPING. step_count = 0 is ignored.
- RUNNING
  - cause → HALTING.
- STEPPING
  - each cycle with ep = 1 decrements steps_left.
  - decrement to 0 is a step-expiry cause → HALTING.
  - any other cause → HALTING with steps_left cleared to 0.
- HALTING
  - sub-flag armed is set by d18.
  - d35 while armed → ep11 = 1 for one cycle; next cycle → STOPPED and armed cleared.
  - start/resume/single/multi pulses are ignored.

**Simultaneous events**
- cause and p_start in STOPPED in the same cycle: stop wins; stay STOPPED, start suppressed.
- d18 and d35 in the same cycle with armed = 0: arms only; ep11 waits for the next d35.

## Timing
**Reset values**
- state STOPPED, stop_neg 0, running 0, start 0, ep11 0.
- extended_pos 0, extended_neg 1, steps_left 0, armed 0, debounce state low.
- single_ep = sep2 and epsep = ep | sep2 (combinational).

**Latencies**
- Button latency: a raw level held high produces its pulse exactly DEBOUNCE_CYCLES+3 rising edges after first being sampled.
- Pulse width: exactly 1 cycle; no repeat while the button is held.
- State transitions: registered; take effect on the edge after the causing pulse.
- stop_neg follows state combinationally from the state register; it stays 1 throughout HALTING.
- ep11: asserted in the cycle after the d35 sample (registered); stop_neg falls the following cycle.

**Edge cases**
- steps_left: decrements saturate at 0; it never wraps.
- Reset mid-HALTING: returns to STOPPED with no ep11 emitted.

## Configuration
CTRL_PANEL_MULTISTEP_EN:
- **Defined:** btn_multi, step_count, the STEPPING state and the steps_left counter are compiled in.
- **Undefined:**
  - those elements are removed;
  - btn_multi and step_count are ignored;
  - steps_left is tied to 0;
  - the state machine has only STOPPED/RUNNING/HALTING.

## Test plan
- **Debounce:** DEBOUNCE_CYCLES=4; btn_start bounces 1-0-1 over 3 cycles, then is held high → exactly one start pulse, 7 edges after the last rise; state RUNNING.
- **Halt sequence:** in RUNNING, c22 pulse → stop_neg stays 1; d18, then d35 three cycles later → ep11 high one cycle, stop_neg 0 the next cycle.
- **Multi-step:** step_count=3, p_multi, then 3 ep pulses → steps_left 3→2→1→0, HALTING; after d18/d35 → STOPPED.
- **Simultaneous:** btn_stop and btn_start pulses coincide in STOPPED → no start pulse, stop_neg stays 0.
- **Extended/reset:** two p_extended pulses → extended_pos 1 then 0; reset_neg low during HALTING with armed=1 → next cycle STOPPED, ep11 never asserts.
- **Macro off:** build without CTRL_PANEL_MULTISTEP_EN; p_multi with step_count=5 → state stays STOPPED, steps_left 0.
